corral_game_engine: RTL and testbench

Game core for the Corral tapeout design. Owns the cowboy and horse positions on a 16-slot circular track, the turn counter, and the win/loss decision. Sits directly downstream of the top-level I/O wrapper, which forwards enter/move and registers gameover/lostwon/ready back to the pins. Horse motion comes from an on-block LFSR.

---
 rtl/corral_pkg.sv | 21 ++
 rtl/corral_game_engine_if.sv | 32 +++
 rtl/corral_lfsr.sv | 25 ++
 rtl/corral_game_engine.sv | 141 ++++++++++++++
 tb/tb_corral_game_engine.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/corral_pkg.sv
// Shared types and constants for the Corral game engine.
//   state_t    : engine FSM states
//   POS_W      : width of a track slot index (16-slot circular track)
//   HORSE_BASE : horse start slot before the random 0..3 offset
//   LFSR_TAPS  : feedback mask for x^8+x^6+x^5+x^4+1 (bit 7 = x^8 term)
//   wrap_add   : add a signed 3-bit step to a slot, wrapping mod 16
package corral_pkg;

  typedef enum logic [2:0] {OVER, WAIT, COWBOY, HORSE, JUDGE} state_t;

  localparam int POS_W = 4;
  localparam logic [POS_W-1:0] HORSE_BASE = 4'd8;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Sign-extending the step and truncating the sum gives mod-16 wrap for free.
  function automatic logic [POS_W-1:0] wrap_add(input logic [POS_W-1:0] pos,
                                                 input logic [2:0] step);
    return pos + {step[2], step};
  endfunction

endpackage

// File: rtl/corral_game_engine_if.sv
// Command/status bundle between the I/O wrapper (master) and the engine (slave).
//   enter      : command strobe, honoured only while ready=1
//   move       : signed cowboy step, -4..+3
//   cowboyPos  : cowboy slot 0..15
//   horsePos   : horse slot 0..15
//   gameover   : 1 = no game in progress
//   lostwon    : 1 = last game won (valid while gameover=1)
//   ready      : engine accepts enter this cycle
//   turns_left : remaining turns in current game
interface corral_game_engine_if;
  import corral_pkg::*;

  logic             enter;
  logic [2:0]       move;
  logic [POS_W-1:0] cowboyPos;
  logic [POS_W-1:0] horsePos;
  logic             gameover;
  logic             lostwon;
  logic             ready;
  logic [3:0]       turns_left;

  modport master (
    output enter, move,
    input  cowboyPos, horsePos, gameover, lostwon, ready, turns_left
  );

  modport slave (
    input  enter, move,
    output cowboyPos, horsePos, gameover, lostwon, ready, turns_left
  );

endinterface

// File: rtl/corral_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
//   clock   : system clock
//   reset_n : synchronous active-low reset, loads SEED (0 is forced to 1)
//   q       : current LFSR state, never zero
module corral_lfsr
  import corral_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [7:0] q
);

  // An all-zero state would lock the register, so a zero seed is replaced.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock) begin
    if (!reset_n) q <= SEED_EFF;
    else          q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/corral_game_engine.sv
// Corral game core: cowboy/horse positions on a 16-slot ring, turn counter,
// win/loss decision. One turn = WAIT -> COWBOY -> HORSE -> JUDGE; a catch
// on the cowboy step skips HORSE.
//   clock   : system clock, all state on posedge
//   reset_n : synchronous active-low reset
//   bus     : command/status bundle (slave side), all outputs registered
module corral_game_engine
  import corral_pkg::*;
#(
  parameter int unsigned MAX_TURNS = 12,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  corral_game_engine_if.slave   bus
);

  state_t           state_q, state_d;
  logic [2:0]       move_q, move_d;
  logic             win_q, win_d;
  logic [POS_W-1:0] cowboy_q, cowboy_d;
  logic [POS_W-1:0] horse_q, horse_d;
  logic [3:0]       turns_q, turns_d;
  logic             gameover_q, gameover_d;
  logic             lostwon_q, lostwon_d;
  logic             ready_q, ready_d;

  logic [7:0]       lfsr_q;
  logic             lfsr_unused;
  logic [POS_W-1:0] cowboy_sum;
  logic             caught;
  logic [POS_W-1:0] horse_cand;

  corral_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .q       (lfsr_q)
  );

  // Only the low three bits steer the game; the rest just keep the sequence long.
  assign lfsr_unused = ^lfsr_q[7:3];

  assign cowboy_sum = wrap_add(cowboy_q, move_q);
  assign caught     = (cowboy_sum == horse_q);
  assign horse_cand = lfsr_q[2] ? horse_q - {2'b00, lfsr_q[1:0]}
                                : horse_q + {2'b00, lfsr_q[1:0]};

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= OVER;
    else          state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output is given a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OVER:    if (bus.enter) state_d = WAIT;
      WAIT:    if (bus.enter) state_d = COWBOY;
      COWBOY:  state_d = caught ? JUDGE : HORSE;
      HORSE:   state_d = JUDGE;
      JUDGE:   state_d = (win_q || turns_q == 4'd1) ? OVER : WAIT;
      default: state_d = OVER;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    move_d     = move_q;
    win_d      = win_q;
    cowboy_d   = cowboy_q;
    horse_d    = horse_q;
    turns_d    = turns_q;
    gameover_d = gameover_q;
    lostwon_d  = lostwon_q;
    unique case (state_q)
      OVER: if (bus.enter) begin
        cowboy_d   = '0;
        horse_d    = HORSE_BASE + {2'b00, lfsr_q[1:0]};
        turns_d    = 4'(MAX_TURNS);
        gameover_d = 1'b0;
      end
      WAIT: if (bus.enter) move_d = bus.move;
      COWBOY: begin
        cowboy_d = cowboy_sum;
        win_d    = caught;
      end
      // The horse refuses to step onto the cowboy, so only the cowboy can catch.
      HORSE: if (horse_cand != cowboy_q) horse_d = horse_cand;
      JUDGE: begin
        turns_d = turns_q - 4'd1;
        win_d   = 1'b0;
        if (win_q) begin
          gameover_d = 1'b1;
          lostwon_d  = 1'b1;
        end else if (turns_q == 4'd1) begin
          gameover_d = 1'b1;
          lostwon_d  = 1'b0;
        end
      end
      default: ;
    endcase
    // ready is registered from the state being entered, so it lines up with it.
    ready_d = (state_d == OVER) || (state_d == WAIT);
  end

  // Datapath registers.
  // NOTE: all of these are few flops with defined reset values; nothing here
  // is a memory array, so resetting every one of them is cheap and safe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      move_q     <= '0;
      win_q      <= 1'b0;
      cowboy_q   <= '0;
      horse_q    <= HORSE_BASE;
      turns_q    <= '0;
      gameover_q <= 1'b1;
      lostwon_q  <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      move_q     <= move_d;
      win_q      <= win_d;
      cowboy_q   <= cowboy_d;
      horse_q    <= horse_d;
      turns_q    <= turns_d;
      gameover_q <= gameover_d;
      lostwon_q  <= lostwon_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.cowboyPos  = cowboy_q;
  assign bus.horsePos   = horse_q;
  assign bus.turns_left = turns_q;
  assign bus.gameover   = gameover_q;
  assign bus.lostwon    = lostwon_q;
  assign bus.ready      = ready_q;

endmodule

// File: tb/tb_corral_game_engine.sv
// Self-checking bench for corral_game_engine. A game-rule model (positions,
// turns, win/loss) plus an LFSR sequence model predict every output.
module tb_corral_game_engine;

  localparam int unsigned MAX_TURNS = 12;
  localparam logic [7:0]  SEED      = 8'hA5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  corral_game_engine_if bus ();

  corral_game_engine #(.MAX_TURNS(MAX_TURNS), .LFSR_SEED(SEED)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Pseudo-random sequence model: x^8+x^6+x^5+x^4+1, shifted in at bit 0.
  logic [7:0] lf;
  always @(posedge clock) begin
    if (!reset_n) lf <= SEED;
    else          lf <= {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
  end

  // Game model.
  int mc, mh, mt;
  bit mgo, mlw;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gameover"}, 8'(bus.gameover), 8'd1);
    check({tag, "_lostwon"},  8'(bus.lostwon),  8'd0);
    check({tag, "_ready"},    8'(bus.ready),    8'd1);
    check({tag, "_cowboy"},   8'(bus.cowboyPos), 8'd0);
    check({tag, "_horse"},    8'(bus.horsePos),  8'd8);
    check({tag, "_turns"},    8'(bus.turns_left), 8'd0);
  endtask

  task automatic model_reset();
    mc = 0; mh = 8; mt = 0; mgo = 1; mlw = 0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && bus.ready !== 1'b1; i++) @(negedge clock);
    check("ready_timeout", 8'(bus.ready), 8'd1);
  endtask

  task automatic start_game();
    int h_exp;
    wait_ready();
    bus.enter = 1'b1;
    bus.move  = 3'($urandom);
    h_exp = 8 + int'(lf[1:0]);
    @(negedge clock);
    bus.enter = 1'b0;
    mc = 0; mh = h_exp; mt = MAX_TURNS; mgo = 0;
    check("start_gameover", 8'(bus.gameover),   8'd0);
    check("start_turns",    8'(bus.turns_left), 8'(mt));
    check("start_cowboy",   8'(bus.cowboyPos),  8'd0);
    check("start_horse",    8'(bus.horsePos),   8'(mh));
    check("start_ready",    8'(bus.ready),      8'd1);
    check("start_lostwon",  8'(bus.lostwon),    8'(mlw));
  endtask

  // One turn; with spam=1 enter stays high while the engine is busy.
  task automatic play_turn(input int m, input bit spam);
    int step, cand;
    wait_ready();
    bus.enter = 1'b1;
    bus.move  = 3'(m);
    @(negedge clock);
    if (!spam) bus.enter = 1'b0;
    check("busy_ready0", 8'(bus.ready), 8'd0);
    @(negedge clock);
    mc = (mc + m) & 15;
    check("cowboy_pos", 8'(bus.cowboyPos), 8'(mc));
    if (mc == mh) begin
      @(negedge clock);
      mt--; mgo = 1; mlw = 1;
      check("win_horse",    8'(bus.horsePos),   8'(mh));
      check("win_gameover", 8'(bus.gameover),   8'd1);
      check("win_lostwon",  8'(bus.lostwon),    8'd1);
      check("win_turns",    8'(bus.turns_left), 8'(mt));
      check("win_ready",    8'(bus.ready),      8'd1);
    end else begin
      check("busy_ready1", 8'(bus.ready), 8'd0);
      step = int'(lf[1:0]);
      cand = lf[2] ? ((mh - step) & 15) : ((mh + step) & 15);
      if (cand != mc) mh = cand;
      @(negedge clock);
      check("horse_pos",   8'(bus.horsePos), 8'(mh));
      check("busy_ready2", 8'(bus.ready),    8'd0);
      @(negedge clock);
      mt--;
      if (mt == 0) begin mgo = 1; mlw = 0; end
      check("judge_turns",    8'(bus.turns_left), 8'(mt));
      check("judge_gameover", 8'(bus.gameover),   8'(mgo));
      check("judge_lostwon",  8'(bus.lostwon),    8'(mlw));
      check("judge_ready",    8'(bus.ready),      8'd1);
      check("judge_nocatch",  8'(bus.cowboyPos == bus.horsePos), 8'd0);
    end
    bus.enter = 1'b0;
  endtask

  initial begin
    int d, m, won, n;
    bus.enter = 1'b0;
    bus.move  = 3'd0;
    model_reset();

    // Reset held two cycles.
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset("reset");
    reset_n = 1'b1;

    // Start, wrap 0-1=15, then finish with random moves (some with held enter).
    start_game();
    play_turn(-1, 1'b0);
    n = 0;
    while (!mgo && n < 20) begin
      play_turn(int'($urandom_range(0, 7)) - 4, 1'(n % 2));
      n++;
    end
    check("game1_over", 8'(bus.gameover), 8'd1);

    // Loss by exhaustion: move=0 every turn.
    start_game();
    for (int i = 0; i < int'(MAX_TURNS) && !mgo; i++) play_turn(0, 1'b0);
    check("loss_gameover", 8'(bus.gameover),   8'd1);
    check("loss_lostwon",  8'(bus.lostwon),    8'd0);
    check("loss_turns",    8'(bus.turns_left), 8'd0);

    // Chase the horse until a game is won.
    won = 0;
    for (int g = 0; g < 30 && won == 0; g++) begin
      start_game();
      n = 0;
      while (!mgo && n < 20) begin
        d = (mh - mc) & 15;
        if (d >= 8) d -= 16;
        m = (d > 3) ? 3 : ((d < -4) ? -4 : d);
        play_turn(m, 1'(g % 2));
        n++;
      end
      won = int'(mlw);
    end
    check("win_seen", 8'(won), 8'd1);

    // Reset while the engine sits in HORSE.
    start_game();
    wait_ready();
    bus.enter = 1'b1;
    bus.move  = 3'd1;
    @(negedge clock);
    bus.enter = 1'b0;
    @(negedge clock);
    check("pre_reset_cowboy", 8'(bus.cowboyPos), 8'd1);
    reset_n = 1'b0;
    @(negedge clock);
    check_reset("midreset");
    reset_n = 1'b1;
    model_reset();
    start_game();
    play_turn(int'($urandom_range(0, 7)) - 4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so a stuck engine still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
